// File: rtl/axis_framebuffer_reader.sv
// Streams a framebuffer out of memory: 16-beat INCR AXI4 reads feed a credit-managed
// FIFO whose head drives an AXI-Stream toward the display path.
module axis_framebuffer_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  start_stream,
    input  logic [ADDR_WIDTH-1:0] fb_addr,
    input  logic [19:0]           fb_size,
    output logic                  fb_streamed,
    output logic                  rresp_err,
    output logic [ID_WIDTH-1:0]   m_mem_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_mem_axi_araddr,
    output logic [7:0]            m_mem_axi_arlen,
    output logic [2:0]            m_mem_axi_arsize,
    output logic [1:0]            m_mem_axi_arburst,
    output logic                  m_mem_axi_arlock,
    output logic [3:0]            m_mem_axi_arcache,
    output logic [2:0]            m_mem_axi_arprot,
    output logic                  m_mem_axi_arvalid,
    input  logic                  m_mem_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_mem_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_mem_axi_rdata,
    input  logic [1:0]            m_mem_axi_rresp,
    input  logic                  m_mem_axi_rlast,
    input  logic                  m_mem_axi_rvalid,
    output logic                  m_mem_axi_rready,
    output logic                  m_disp_axis_tvalid,
    input  logic                  m_disp_axis_tready,
    output logic                  m_disp_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_disp_axis_tdata
);

    localparam int FB_SIZE_IN_PIXEL_LG = 20;
    localparam int PIXEL_SIZE          = 16;
    localparam int BYTES               = DATA_WIDTH / 8;
    localparam int PTR_W               = $clog2(FIFO_DEPTH);
    localparam int CNT_W               = PTR_W + 1;
    localparam int BEAT_W              = FB_SIZE_IN_PIXEL_LG + 1;
    localparam int SUM_W               = BEAT_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [ADDR_WIDTH-1:0] addr_q, araddr_q;
    logic [BEAT_W-1:0]     beats_left_q, total_q, out_beat_q;
    logic [7:0]            arlen_q;
    logic                  arvalid_q, fb_streamed_q, rresp_err_q;

    logic                  push, pop, ar_hs, last_beat, credit_ok;
    logic [8:0]            ar_beats;
    logic [BEAT_W-1:0]     burst_beats, total_calc;
    logic [SUM_W-1:0]      credit_sum, size_bytes;
    logic                  unused_sig;

    // Beats arriving while idle belong to an abandoned frame and are dropped.
    assign push        = m_mem_axi_rvalid && (state_q != S_IDLE);
    assign pop         = m_disp_axis_tvalid && m_disp_axis_tready;
    assign ar_hs       = arvalid_q && m_mem_axi_arready;
    assign ar_beats    = {1'b0, arlen_q} + 9'd1;
    assign last_beat   = (out_beat_q == total_q - BEAT_W'(1));
    assign burst_beats = (beats_left_q > BEAT_W'(16)) ? BEAT_W'(16) : beats_left_q;

    // Credit covers both buffered beats and beats still owed by memory.
    assign credit_sum  = SUM_W'(count_q) + SUM_W'(outstanding_q) + SUM_W'(burst_beats);
    assign credit_ok   = (credit_sum <= SUM_W'(FIFO_DEPTH));

    assign size_bytes  = SUM_W'(fb_size) * SUM_W'(PIXEL_SIZE / 8);
    assign total_calc  = BEAT_W'((size_bytes + SUM_W'(BYTES - 1)) / SUM_W'(BYTES));

    assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    assign outstanding_d = outstanding_q + (ar_hs ? CNT_W'(ar_beats) : '0) - CNT_W'(push);

    assign m_mem_axi_arid     = '0;
    assign m_mem_axi_araddr   = araddr_q;
    assign m_mem_axi_arlen    = arlen_q;
    assign m_mem_axi_arsize   = 3'($clog2(BYTES));
    assign m_mem_axi_arburst  = 2'b01;
    assign m_mem_axi_arlock   = 1'b0;
    assign m_mem_axi_arcache  = 4'b0011;
    assign m_mem_axi_arprot   = 3'b000;
    assign m_mem_axi_arvalid  = arvalid_q;
    assign m_mem_axi_rready   = 1'b1;

    assign m_disp_axis_tvalid = (count_q != '0);
    assign m_disp_axis_tdata  = fifo_mem[rd_ptr_q];
    assign m_disp_axis_tlast  = m_disp_axis_tvalid && last_beat;

    assign fb_streamed = fb_streamed_q;
    assign rresp_err   = rresp_err_q;

    assign unused_sig = ^{m_mem_axi_rid, m_mem_axi_rlast, fb_addr[5:0]};

    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= m_mem_axi_rdata;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            addr_q        <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arvalid_q     <= 1'b0;
            beats_left_q  <= '0;
            total_q       <= '0;
            out_beat_q    <= '0;
            fb_streamed_q <= 1'b1;
            rresp_err_q   <= 1'b0;
        end else begin
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (m_mem_axi_rresp != 2'b00) begin
                    rresp_err_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                out_beat_q <= last_beat ? '0 : out_beat_q + BEAT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start_stream && (fb_size != '0)) begin
                        addr_q        <= {fb_addr[ADDR_WIDTH-1:6], 6'b0};
                        beats_left_q  <= total_calc;
                        total_q       <= total_calc;
                        out_beat_q    <= '0;
                        rresp_err_q   <= 1'b0;
                        fb_streamed_q <= 1'b0;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ar_hs) begin
                        arvalid_q    <= 1'b0;
                        addr_q       <= addr_q + ADDR_WIDTH'(ar_beats) * ADDR_WIDTH'(BYTES);
                        beats_left_q <= beats_left_q - BEAT_W'(ar_beats);
                        if (beats_left_q == BEAT_W'(ar_beats)) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (!arvalid_q && credit_ok) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= addr_q;
                        arlen_q   <= 8'(burst_beats - BEAT_W'(1));
                    end
                end
                S_DRAIN: begin
                    if (pop && last_beat) begin
                        fb_streamed_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_framebuffer_reader.sv
// Directed bench for axis_framebuffer_reader: AXI4 read slave with address-derived
// data, AXI-Stream sink, and per-frame burst/beat checks against hand-written vectors.
module tb_axis_framebuffer_reader;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int IW    = 8;
    localparam int DEPTH = 64;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          start_stream;
    logic [AW-1:0] fb_addr;
    logic [19:0]   fb_size;
    logic          fb_streamed, rresp_err;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic          arvalid, arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic          tvalid, tready, tlast;
    logic [DW-1:0] tdata;

    always #5 aclk = ~aclk;

    axis_framebuffer_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .resetn(resetn), .start_stream(start_stream),
        .fb_addr(fb_addr), .fb_size(fb_size),
        .fb_streamed(fb_streamed), .rresp_err(rresp_err),
        .m_mem_axi_arid(arid), .m_mem_axi_araddr(araddr), .m_mem_axi_arlen(arlen),
        .m_mem_axi_arsize(arsize), .m_mem_axi_arburst(arburst), .m_mem_axi_arlock(arlock),
        .m_mem_axi_arcache(arcache), .m_mem_axi_arprot(arprot),
        .m_mem_axi_arvalid(arvalid), .m_mem_axi_arready(arready),
        .m_mem_axi_rid(rid), .m_mem_axi_rdata(rdata), .m_mem_axi_rresp(rresp),
        .m_mem_axi_rlast(rlast), .m_mem_axi_rvalid(rvalid), .m_mem_axi_rready(rready),
        .m_disp_axis_tvalid(tvalid), .m_disp_axis_tready(tready),
        .m_disp_axis_tlast(tlast), .m_disp_axis_tdata(tdata)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    logic [31:0]   r_pend_addr[$];
    logic [7:0]    r_pend_len[$];
    int            r_idx = 0;
    int            r_beat_cnt = 0;
    int            err_at = -1;
    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    logic [DW-1:0] exp_q[$];
    bit            ar_rand = 1'b0;
    bit            r_rand = 1'b0;
    int            tr_mode = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Memory slave: R beats come from bursts accepted on earlier edges only.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
        forever begin
            @(negedge aclk);
            if (r_pend_addr.size() > 0 && (!r_rand || $urandom_range(0, 3) != 0)) begin
                rvalid = 1'b1;
                rdata  = mem_word(r_pend_addr[0] + 32'(4 * r_idx));
                rresp  = (r_beat_cnt == err_at) ? 2'b10 : 2'b00;
                rlast  = (r_idx == int'(r_pend_len[0]));
                r_beat_cnt++;
                r_idx++;
                if (r_idx > int'(r_pend_len[0])) begin
                    void'(r_pend_addr.pop_front());
                    void'(r_pend_len.pop_front());
                    r_idx = 0;
                end
            end else begin
                rvalid = 1'b0;
                rresp  = 2'b00;
                rlast  = 1'b0;
            end
            arready = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (arvalid && arready) begin
                ar_addr_q.push_back(araddr);
                ar_len_q.push_back(arlen);
                r_pend_addr.push_back(araddr);
                r_pend_len.push_back(arlen);
            end
        end
    end

    initial begin
        tready = 1'b0;
        forever begin
            @(negedge aclk);
            tready = (tr_mode == 0) ? 1'b0 : (tr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (tvalid && tready && resetn) begin
                got_data.push_back(tdata);
                got_last.push_back(tlast);
            end
        end
    end

    task automatic start_frame(input logic [31:0] addr, input logic [19:0] size);
        ar_addr_q.delete();
        ar_len_q.delete();
        got_data.delete();
        got_last.delete();
        r_beat_cnt = 0;
        @(negedge aclk);
        fb_addr = addr;
        fb_size = size;
        start_stream = 1'b1;
        @(negedge aclk);
        start_stream = 1'b0;
        check("streaming_flag", 64'(fb_streamed), 64'(0));
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (fb_streamed !== 1'b1 && i < budget) begin
            @(negedge aclk);
            i++;
        end
        check("frame_done", 64'(fb_streamed), 64'(1));
    endtask

    task automatic check_ar(input int idx, input logic [31:0] ea, input logic [7:0] el);
        logic [31:0] a;
        logic [7:0]  l;
        a = (idx < ar_addr_q.size()) ? ar_addr_q[idx] : 'x;
        l = (idx < ar_len_q.size()) ? ar_len_q[idx] : 'x;
        check($sformatf("ar%0d_addr", idx), 64'(a), 64'(ea));
        check($sformatf("ar%0d_len", idx), 64'(l), 64'(el));
    endtask

    task automatic check_beats(input logic [31:0] base, input int n);
        logic [DW-1:0] e, d;
        logic          lst;
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(base + 32'(4 * i)));
        check("beat_count", 64'(got_data.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            e   = exp_q.pop_front();
            d   = (i < got_data.size()) ? got_data[i] : 'x;
            lst = (i < got_last.size()) ? got_last[i] : 1'bx;
            check($sformatf("beat%0d_data", i), 64'(d), 64'(e));
            check($sformatf("beat%0d_last", i), 64'(lst), 64'(i == n - 1));
        end
    endtask

    initial begin
        int  base;
        int  i;
        bit  saw_arvalid;
        resetn = 1'b0; start_stream = 1'b0; fb_addr = '0; fb_size = '0;
        repeat (3) @(negedge aclk);
        check("rst_fb_streamed", 64'(fb_streamed), 64'(1));
        check("rst_rresp_err", 64'(rresp_err), 64'(0));
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_tvalid", 64'(tvalid), 64'(0));
        check("rst_tlast", 64'(tlast), 64'(0));
        check("rready_high", 64'(rready), 64'(1));
        resetn = 1'b1;
        @(negedge aclk);

        // 64 pixels -> two full bursts
        start_frame(32'h1000, 20'd64);
        wait_done(2000);
        check("ar_count_t1", 64'(ar_addr_q.size()), 64'(2));
        check_ar(0, 32'h1000, 8'd15);
        check_ar(1, 32'h1040, 8'd15);
        check_beats(32'h1000, 32);
        check("arid", 64'(arid), 64'(0));
        check("arsize", 64'(arsize), 64'(2));
        check("arburst", 64'(arburst), 64'(1));
        check("arlock", 64'(arlock), 64'(0));
        check("arcache", 64'(arcache), 64'(3));
        check("arprot", 64'(arprot), 64'(0));

        // 40 pixels -> 20 beats, short tail burst
        start_frame(32'h1000, 20'd40);
        wait_done(2000);
        check("ar_count_t2", 64'(ar_addr_q.size()), 64'(2));
        check_ar(0, 32'h1000, 8'd15);
        check_ar(1, 32'h1040, 8'd3);
        check_beats(32'h1000, 20);

        // 3 pixels -> 2 beats; unaligned address low bits dropped
        start_frame(32'h2013, 20'd3);
        wait_done(500);
        check("ar_count_t3", 64'(ar_addr_q.size()), 64'(1));
        check_ar(0, 32'h2000, 8'd1);
        check_beats(32'h2000, 2);

        // zero-size start is ignored
        ar_addr_q.delete();
        @(negedge aclk);
        fb_addr = 32'h5000; fb_size = 20'd0; start_stream = 1'b1;
        @(negedge aclk);
        start_stream = 1'b0;
        saw_arvalid = 1'b0;
        repeat (20) begin
            @(negedge aclk);
            if (arvalid) saw_arvalid = 1'b1;
        end
        check("size0_arvalid", 64'(saw_arvalid), 64'(0));
        check("size0_streamed", 64'(fb_streamed), 64'(1));

        // display stalled: credits allow exactly four bursts
        tr_mode = 0;
        start_frame(32'h4000, 20'd256);
        repeat (300) @(negedge aclk);
        check("stall_ar_count", 64'(ar_addr_q.size()), 64'(4));
        check("stall_arvalid", 64'(arvalid), 64'(0));
        check("stall_tvalid", 64'(tvalid), 64'(1));
        tr_mode = 1;
        wait_done(3000);
        check("ar_count_t5", 64'(ar_addr_q.size()), 64'(8));
        for (int k = 0; k < 8; k++) check_ar(k, 32'h4000 + 32'(64 * k), 8'd15);
        check_beats(32'h4000, 128);

        // random stalls, SLVERR on beat 5, ignored mid-frame start
        ar_rand = 1'b1; r_rand = 1'b1; tr_mode = 2; err_at = 5;
        start_frame(32'h8000, 20'd100);
        repeat (6) @(negedge aclk);
        fb_addr = 32'h9000; fb_size = 20'd8; start_stream = 1'b1;
        @(negedge aclk);
        start_stream = 1'b0;
        wait_done(5000);
        ar_rand = 1'b0; r_rand = 1'b0; tr_mode = 1; err_at = -1;
        check("ar_count_t6", 64'(ar_addr_q.size()), 64'(4));
        check_ar(0, 32'h8000, 8'd15);
        check_ar(1, 32'h8040, 8'd15);
        check_ar(2, 32'h8080, 8'd15);
        check_ar(3, 32'h80C0, 8'd1);
        check_beats(32'h8000, 50);
        repeat (5) @(negedge aclk);
        check("rresp_err_sticky", 64'(rresp_err), 64'(1));

        // reset mid-frame after 10 beats
        start_frame(32'h1000, 20'd64);
        check("rresp_err_cleared", 64'(rresp_err), 64'(0));
        i = 0;
        while (got_data.size() < 10 && i < 500) begin
            @(negedge aclk);
            i++;
        end
        check("ten_beats_seen", 64'(got_data.size() >= 10), 64'(1));
        resetn = 1'b0;
        #1;
        check("mid_rst_arvalid", 64'(arvalid), 64'(0));
        check("mid_rst_tvalid", 64'(tvalid), 64'(0));
        check("mid_rst_tlast", 64'(tlast), 64'(0));
        check("mid_rst_streamed", 64'(fb_streamed), 64'(1));
        check("mid_rst_rresp_err", 64'(rresp_err), 64'(0));
        repeat (2) @(negedge aclk);
        resetn = 1'b1;
        base = got_data.size();
        i = 0;
        while (r_pend_addr.size() > 0 && i < 300) begin
            @(negedge aclk);
            i++;
        end
        repeat (3) @(negedge aclk);
        check("stale_pending_done", 64'(r_pend_addr.size()), 64'(0));
        check("stale_dropped", 64'(got_data.size()), 64'(base));
        check("stale_tvalid", 64'(tvalid), 64'(0));

        // clean frame after reset
        start_frame(32'h3000, 20'd32);
        wait_done(1000);
        check("ar_count_t8", 64'(ar_addr_q.size()), 64'(1));
        check_ar(0, 32'h3000, 8'd15);
        check_beats(32'h3000, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_framebuffer_reader.md
Name: axis_framebuffer_reader

Overview:
- Reads a framebuffer from memory over an AXI4 read master.
- Emits the framebuffer as an AXI-Stream toward the display path.
- Counterpart of the framebuffer writer: same fb_addr/fb_size programming model, same 16-bit pixel format, same 16-beat INCR bursts.
- Sits between the memory interconnect and the display output/scaler, buffering read data in an internal FIFO so AXI reads never stall on display backpressure.

Parameters:
- DATA_WIDTH, 32, AXI and AXIS data width in bits (multiple of 16).
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 8, AXI ID width.
- FIFO_DEPTH, 64, read-data FIFO depth in beats (power of two, >= 16).
- FB_SIZE_IN_PIXEL_LG (local), 20, width of fb_size.
- PIXEL_SIZE (local), 16, bits per pixel.

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start_stream  in  1  start streaming one frame (sampled while idle)
- fb_addr  in  ADDR_WIDTH  frame start byte address; must be 64-byte aligned (low 6 bits ignored)
- fb_size  in  20  frame size in pixels
- fb_streamed  out  1  high when idle and the last frame is fully streamed
- rresp_err  out  1  sticky: any beat of the current frame had rresp != OKAY
- m_mem_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1  AXI read address channel
- m_mem_axi_arready  in  1
- m_mem_axi_rid  in  ID_WIDTH
- m_mem_axi_rdata  in  DATA_WIDTH
- m_mem_axi_rresp  in  2
- m_mem_axi_rlast  in  1
- m_mem_axi_rvalid  in  1
- m_mem_axi_rready  out  1
- m_disp_axis_tvalid  out  1
- m_disp_axis_tready  in  1
- m_disp_axis_tlast  out  1  last beat of frame
- m_disp_axis_tdata  out  DATA_WIDTH

Behaviour:
- Reset (async, resetn=0):
  - fb_streamed=1, rresp_err=0, arvalid=0, tvalid=0, tlast=0.
  - FIFO emptied; outstanding and beat counters cleared; state IDLE.
  - Reset mid-frame abandons the frame immediately; in-flight R beats arriving after reset release are dropped (rready=1, data discarded).
- Constants:
  - arid=0, arsize=$clog2(DATA_WIDTH/8), arburst=INCR(01), arlock=0, arcache=0011, arprot=000.
- Size arithmetic:
  - totalBeats = ceil(fb_size*2 / (DATA_WIDTH/8)), computed on 21 bits.
  - Example at DATA_WIDTH=32: fb_size=3 gives 2 beats.
- States:
  - IDLE: start_stream=1 and fb_size!=0 latches address/beat count, clears rresp_err, sets fb_streamed=0, moves to ISSUE. start_stream with fb_size=0 is ignored; fb_streamed stays 1. start_stream outside IDLE is ignored.
  - ISSUE: issue AR bursts (see below). After the final AR handshake, move to DRAIN.
  - DRAIN: wait until every beat has left on AXIS with the tlast handshake, then set fb_streamed=1 in the following cycle and return to IDLE.
- AR bursts:
  - arlen = min(15, remainingBeats-1).
  - araddr starts at fb_addr and advances by (arlen+1)*DATA_WIDTH/8 after each handshake.
  - arvalid and the AR payload stay stable until arready.
  - First arvalid is asserted no earlier than the cycle after start_stream is accepted.
- Credit flow control:
  - outstanding = beats requested but not yet received.
  - arvalid is raised only when fifoCount + outstanding + arlen + 1 <= FIFO_DEPTH.
  - On an AR handshake, outstanding += arlen+1; on each R handshake, outstanding -= 1. Both may happen in the same cycle.
  - Consequently rready is constant 1 and the FIFO never overflows.
- R channel:
  - rdata is pushed into the FIFO; rlast and rid are ignored.
  - rresp != 00 on any beat sets rresp_err; the data is still forwarded.
- AXIS output:
  - Driven directly from the FIFO head: tvalid = !empty.
  - tdata/tvalid/tlast are held stable while tvalid && !tready.
  - Latency from R beat accepted to tvalid is 1 cycle.
  - tlast=1 only on beat totalBeats-1 of the frame; an output beat counter tracks this.
- Simultaneous push and pop of the FIFO in one cycle keeps fifoCount unchanged; full and empty boundaries must hold exactly.

Test Plan:
- DATA_WIDTH=32, fb_addr=0x1000, fb_size=64 -> 2 AR bursts (0x1000 arlen=15, 0x1040 arlen=15), 32 AXIS beats carrying memory data in order, tlast only on beat 31, fb_streamed returns 1.
- fb_size=40 -> 20 beats: AR 0x1000 arlen=15, then 0x1040 arlen=3; tlast on beat 19.
- fb_size=3 -> one AR with arlen=1, 2 AXIS beats, tlast on beat 1; fb_size=0 -> no arvalid, fb_streamed stays 1.
- tready held 0 with FIFO_DEPTH=64, fb_size=256 (128 beats) -> exactly 4 bursts issued, then arvalid stays 0. After tready=1, the remaining 4 bursts follow and no beat is lost or duplicated.
- Random arready/rvalid/tready stalls plus rresp=SLVERR on beat 5 -> data order intact, rresp_err=1 until the next start; start_stream pulsed mid-frame is ignored.
- resetn=0 asserted mid-frame after 10 beats -> all outputs at reset values immediately. A following frame of fb_size=32 streams exactly 16 beats correctly.
